// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter and its helpers
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
endpackage

// File: rtl/mem_be_gen.sv
// mem_be_gen: byte-lane enables, lane-replicated write data and misalignment from size/offset
module mem_be_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);
  always_comb begin
    be = size == SZ_B ? 4'b0001 << addr_lo : size == SZ_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    misaligned = size == SZ_B ? 1'b0 : size == SZ_H ? addr_lo[0] : |addr_lo;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the CPU and the debug loader,
// sequencing each access as ISSUE, WAIT, RESP with round-robin tie-breaking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_e state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, pick;
  logic we_q, we_d;
  logic [1:0] size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, wdata_rep;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] be;
  logic mis, issue, resp;

  mem_be_gen u_be_gen (
    .size(size_q),
    .addr_lo(addr_q[1:0]),
    .wdata(wdata_q),
    .be(be),
    .wdata_rep(wdata_rep),
    .misaligned(mis)
  );

  // Debug accesses are latched word-aligned so the shared lane logic never flags them.
  always_comb begin
    pick = cpu_req & dbg_req ? ~last_q : (dbg_req ? DBG : CPU);
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    we_d = we_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cpu_req | dbg_req) begin
        state_d = ISSUE;
        gnt_d = pick;
        we_d = pick == DBG ? dbg_we : cpu_we;
        size_d = pick == DBG ? SZ_W : cpu_size;
        addr_d = pick == DBG ? {dbg_addr[AW-1:2], 2'b00} : cpu_addr;
        wdata_d = pick == DBG ? dbg_wdata : cpu_wdata;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = 3'(LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          rdata_d = we_q | mis ? '0 : mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= CPU;
      last_q <= DBG;
      we_q <= 1'b0;
      size_q <= SZ_B;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      we_q <= we_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    issue = state_q == ISSUE;
    resp = state_q == RESP;
    mem_en = issue & ~mis;
    mem_we = issue & ~mis & we_q;
    mem_be = issue ? be : 4'b0000;
    mem_addr = issue ? {addr_q[AW-1:2], 2'b00} : '0;
    mem_wdata = issue ? wdata_rep : '0;
    cpu_ack = resp & gnt_q == CPU;
    dbg_ack = resp & gnt_q == DBG;
    cpu_err = cpu_ack & mis;
    cpu_stall = cpu_req & ~cpu_ack;
    rdata = rdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench over three arbiter instances with LAT of 1, 3 and 4.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        dbg;
    logic        err;
    logic [31:0] rd;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rep;
  } st_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic        err;
    logic [31:0] rd;
  } mis_t;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] eaddr;
    logic [31:0] rd;
  } raw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req [3], cpu_we [3], dbg_req [3], dbg_we [3];
  logic [1:0] cpu_size [3];
  logic [31:0] cpu_addr [3], cpu_wdata [3], dbg_addr [3], dbg_wdata [3];
  logic cpu_ack [3], cpu_err [3], cpu_stall [3], dbg_ack [3], mem_en [3], mem_we [3];
  logic [3:0] mem_be [3];
  logic [31:0] rdata [3], mem_addr [3], mem_wdata [3], mem_rdata [3];
  exp_t sb [$];
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? 1 : g == 1 ? 3 : 4;
    logic [31:0] mem [64];
    logic [31:0] pipe [L];
    mem_port_arbiter #(.AW(32), .DW(32), .LAT(L)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_size(cpu_size[g]),
      .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_ack(cpu_ack[g]), .cpu_err(cpu_err[g]), .cpu_stall(cpu_stall[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]), .dbg_wdata(dbg_wdata[g]),
      .dbg_ack(dbg_ack[g]), .rdata(rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = pipe[L-1];
    // Read data appears exactly L cycles after mem_en; every other slot carries noise.
    always @(posedge clk) begin
      if (rst) for (int i = 0; i < 64; i++) mem[i] <= 32'hDEADBEEF;
      else if (mem_en[g] && mem_we[g])
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) mem[mem_addr[g][7:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][7:2]] : $urandom;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k], cpu_ack[k], cpu_err[k],
           dbg_ack[k], cpu_stall[k], rdata[k]} !== '0)
        $display("FAIL reset[%0d]: en=%b we=%b be=%b addr=%h wdata=%h ack=%b err=%b dack=%b stall=%b rdata=%h, want all 0",
                 k, mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k], cpu_ack[k], cpu_err[k],
                 dbg_ack[k], cpu_stall[k], rdata[k]);
      else passes++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    exp_t e;
    cpu_req[0] = 1'b1;
    cpu_we[0] = 1'b0;
    cpu_size[0] = SZ_W;
    cpu_addr[0] = 32'h10;
    sb.push_back('{dbg: 1'b0, err: 1'b0, rd: 32'hDEADBEEF, due: cyc + 3});
    #1;
    checks++;
    if (cpu_stall[0] !== 1'b1) $display("FAIL read stall c0: got %b want 1", cpu_stall[0]);
    else passes++;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({mem_en[0], cpu_stall[0]} !== {i == 1, i < 3})
        $display("FAIL read c%0d: en=%b stall=%b want en=%b stall=%b", i, mem_en[0], cpu_stall[0], i == 1, i < 3);
      else passes++;
      if (i == 1) begin
        checks++;
        if ({mem_addr[0], mem_be[0], mem_we[0]} !== {32'h10, 4'b1111, 1'b0})
          $display("FAIL read issue: addr=%h be=%b we=%b want 00000010 1111 0", mem_addr[0], mem_be[0], mem_we[0]);
        else passes++;
      end
      if (cpu_ack[0] | dbg_ack[0]) begin
        checks++;
        if (sb.size() == 0) $display("FAIL read unexpected ack at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if ({dbg_ack[0], cpu_err[0], rdata[0], cyc} !== {e.dbg, e.err, e.rd, e.due})
            $display("FAIL read ack: got dbg=%b err=%b rdata=%h cyc=%0d want dbg=%b err=%b rdata=%h cyc=%0d",
                     dbg_ack[0], cpu_err[0], rdata[0], cyc, e.dbg, e.err, e.rd, e.due);
          else passes++;
        end
      end
      if (i == 3) cpu_req[0] = 1'b0;
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL read missing acks: %0d pending want 0", sb.size());
      sb.delete();
    end else passes++;
  endtask

  task automatic test_store();
    exp_t e;
    st_t tab [4] = '{
      '{SZ_B, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5},
      '{SZ_H, 32'h12, 32'h00001234, 4'b1100, 32'h12341234},
      '{SZ_B, 32'h11, 32'hFFFFFF5A, 4'b0010, 32'h5A5A5A5A},
      '{SZ_H, 32'h10, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF}};
    foreach (tab[j]) begin
      cpu_req[0] = 1'b1;
      cpu_we[0] = 1'b1;
      cpu_size[0] = tab[j].sz;
      cpu_addr[0] = tab[j].addr;
      cpu_wdata[0] = tab[j].wd;
      sb.push_back('{dbg: 1'b0, err: 1'b0, rd: 32'h0, due: cyc + 3});
      for (int i = 1; i <= 3; i++) begin
        step();
        if (i == 1) begin
          checks++;
          if ({mem_en[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0]} !== {2'b11, tab[j].be, 32'h10, tab[j].rep})
            $display("FAIL store[%0d]: en=%b we=%b be=%b addr=%h wdata=%h want 1 1 %b 00000010 %h",
                     j, mem_en[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0], tab[j].be, tab[j].rep);
          else passes++;
        end
        if (cpu_ack[0] | dbg_ack[0]) begin
          checks++;
          if (sb.size() == 0) $display("FAIL store unexpected ack at cycle %0d", cyc);
          else begin
            e = sb.pop_front();
            if ({dbg_ack[0], cpu_err[0], rdata[0], cyc} !== {e.dbg, e.err, e.rd, e.due})
              $display("FAIL store ack: got dbg=%b err=%b rdata=%h cyc=%0d want dbg=%b err=%b rdata=%h cyc=%0d",
                       dbg_ack[0], cpu_err[0], rdata[0], cyc, e.dbg, e.err, e.rd, e.due);
            else passes++;
          end
        end
        if (i == 3) cpu_req[0] = 1'b0;
      end
      step();
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL store missing acks: %0d pending want 0", sb.size());
      sb.delete();
    end else passes++;
  endtask

  task automatic test_misaligned();
    exp_t e;
    mis_t tab [5] = '{
      '{SZ_B,  32'h7, 1'b0, 32'hDEADBEEF},
      '{SZ_W,  32'h6, 1'b1, 32'h0},
      '{SZ_H,  32'h5, 1'b1, 32'h0},
      '{2'b11, 32'h2, 1'b1, 32'h0},
      '{2'b11, 32'h8, 1'b0, 32'hDEADBEEF}};
    foreach (tab[j]) begin
      cpu_req[0] = 1'b1;
      cpu_we[0] = 1'b0;
      cpu_size[0] = tab[j].sz;
      cpu_addr[0] = tab[j].addr;
      sb.push_back('{dbg: 1'b0, err: tab[j].err, rd: tab[j].rd, due: cyc + 3});
      for (int i = 1; i <= 3; i++) begin
        step();
        if (i == 1) begin
          checks++;
          if (mem_en[0] !== ~tab[j].err)
            $display("FAIL misaligned[%0d] mem_en: got %b want %b", j, mem_en[0], ~tab[j].err);
          else passes++;
        end
        if (cpu_ack[0] | dbg_ack[0]) begin
          checks++;
          if (sb.size() == 0) $display("FAIL misaligned unexpected ack at cycle %0d", cyc);
          else begin
            e = sb.pop_front();
            if ({dbg_ack[0], cpu_err[0], rdata[0], cyc} !== {e.dbg, e.err, e.rd, e.due})
              $display("FAIL misaligned ack: got dbg=%b err=%b rdata=%h cyc=%0d want dbg=%b err=%b rdata=%h cyc=%0d",
                       dbg_ack[0], cpu_err[0], rdata[0], cyc, e.dbg, e.err, e.rd, e.due);
            else passes++;
          end
        end
        if (i == 3) cpu_req[0] = 1'b0;
      end
      step();
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL misaligned missing acks: %0d pending want 0", sb.size());
      sb.delete();
    end else passes++;
  endtask

  task automatic test_arb();
    exp_t e;
    int c0;
    c0 = cyc;
    cpu_req[1] = 1'b1;
    cpu_we[1] = 1'b0;
    cpu_size[1] = SZ_W;
    cpu_addr[1] = 32'h20;
    dbg_req[1] = 1'b1;
    dbg_we[1] = 1'b0;
    dbg_addr[1] = 32'h24;
    sb.push_back('{dbg: 1'b0, err: 1'b0, rd: 32'hDEADBEEF, due: c0 + 5});
    sb.push_back('{dbg: 1'b1, err: 1'b0, rd: 32'hDEADBEEF, due: c0 + 11});
    sb.push_back('{dbg: 1'b0, err: 1'b0, rd: 32'hDEADBEEF, due: c0 + 17});
    for (int i = 1; i <= 17; i++) begin
      step();
      if (cpu_ack[1] | dbg_ack[1]) begin
        checks++;
        if (sb.size() == 0) $display("FAIL arb unexpected ack at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if ({dbg_ack[1], cpu_err[1], rdata[1], cyc} !== {e.dbg, e.err, e.rd, e.due})
            $display("FAIL arb ack: got dbg=%b err=%b rdata=%h cyc=%0d want dbg=%b err=%b rdata=%h cyc=%0d",
                     dbg_ack[1], cpu_err[1], rdata[1], cyc, e.dbg, e.err, e.rd, e.due);
          else passes++;
        end
      end
      if (i == 17) begin
        cpu_req[1] = 1'b0;
        dbg_req[1] = 1'b0;
      end
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL arb missing acks: %0d pending want 0", sb.size());
      sb.delete();
    end else passes++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    dbg_req[2] = 1'b1;
    dbg_we[2] = 1'b1;
    dbg_addr[2] = 32'h40;
    dbg_wdata[2] = 32'h11111111;
    step();
    checks++;
    if ({mem_en[2], mem_we[2]} !== 2'b11) $display("FAIL reset_mid issue: en=%b we=%b want 1 1", mem_en[2], mem_we[2]);
    else passes++;
    step();
    rst = 1'b1;
    dbg_req[2] = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k], cpu_ack[k], cpu_err[k],
           dbg_ack[k], cpu_stall[k], rdata[k]} !== '0)
        $display("FAIL reset_mid[%0d]: en=%b we=%b be=%b addr=%h wdata=%h ack=%b err=%b dack=%b stall=%b rdata=%h, want all 0",
                 k, mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k], cpu_ack[k], cpu_err[k],
                 dbg_ack[k], cpu_stall[k], rdata[k]);
      else passes++;
    end
    rst = 1'b0;
    cpu_req[2] = 1'b1;
    cpu_we[2] = 1'b0;
    cpu_size[2] = SZ_W;
    cpu_addr[2] = 32'h44;
    dbg_req[2] = 1'b1;
    dbg_we[2] = 1'b0;
    dbg_addr[2] = 32'h40;
    sb.push_back('{dbg: 1'b0, err: 1'b0, rd: 32'hDEADBEEF, due: cyc + 6});
    for (int i = 1; i <= 6; i++) begin
      step();
      if (cpu_ack[2] | dbg_ack[2]) begin
        checks++;
        if (sb.size() == 0) $display("FAIL reset_mid unexpected ack at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if ({dbg_ack[2], cpu_err[2], rdata[2], cyc} !== {e.dbg, e.err, e.rd, e.due})
            $display("FAIL reset_mid ack: got dbg=%b err=%b rdata=%h cyc=%0d want dbg=%b err=%b rdata=%h cyc=%0d",
                     dbg_ack[2], cpu_err[2], rdata[2], cyc, e.dbg, e.err, e.rd, e.due);
          else passes++;
        end
      end
      if (i == 6) begin
        cpu_req[2] = 1'b0;
        dbg_req[2] = 1'b0;
      end
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL reset_mid missing acks: %0d pending want 0", sb.size());
      sb.delete();
    end else passes++;
  endtask

  task automatic test_raw();
    exp_t e;
    raw_t tab [4] = '{
      '{1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 32'h48, 32'h0},
      '{1'b0, 1'b0, 32'h48, 32'h0,        32'h48, 32'hCAFEF00D},
      '{1'b1, 1'b1, 32'h4E, 32'h600DF00D, 32'h4C, 32'h0},
      '{1'b0, 1'b0, 32'h4C, 32'h0,        32'h4C, 32'h600DF00D}};
    foreach (tab[j]) begin
      cpu_req[2] = ~tab[j].dbg;
      cpu_we[2] = tab[j].we;
      cpu_size[2] = SZ_W;
      cpu_addr[2] = tab[j].addr;
      cpu_wdata[2] = tab[j].wd;
      dbg_req[2] = tab[j].dbg;
      dbg_we[2] = tab[j].we;
      dbg_addr[2] = tab[j].addr;
      dbg_wdata[2] = tab[j].wd;
      sb.push_back('{dbg: tab[j].dbg, err: 1'b0, rd: tab[j].rd, due: cyc + 6});
      for (int i = 1; i <= 6; i++) begin
        step();
        if (i == 1) begin
          checks++;
          if ({mem_en[2], mem_we[2], mem_addr[2], mem_be[2]} !== {1'b1, tab[j].we, tab[j].eaddr, 4'hF})
            $display("FAIL raw[%0d] issue: en=%b we=%b addr=%h be=%b want 1 %b %h 1111",
                     j, mem_en[2], mem_we[2], mem_addr[2], mem_be[2], tab[j].we, tab[j].eaddr);
          else passes++;
          cpu_addr[2] = 32'h0;
          dbg_addr[2] = 32'h0;
          cpu_wdata[2] = $urandom;
          dbg_wdata[2] = $urandom;
        end
        if (cpu_ack[2] | dbg_ack[2]) begin
          checks++;
          if (sb.size() == 0) $display("FAIL raw unexpected ack at cycle %0d", cyc);
          else begin
            e = sb.pop_front();
            if ({dbg_ack[2], cpu_err[2], rdata[2], cyc} !== {e.dbg, e.err, e.rd, e.due})
              $display("FAIL raw ack: got dbg=%b err=%b rdata=%h cyc=%0d want dbg=%b err=%b rdata=%h cyc=%0d",
                       dbg_ack[2], cpu_err[2], rdata[2], cyc, e.dbg, e.err, e.rd, e.due);
            else passes++;
          end
        end
        if (i == 6) begin
          cpu_req[2] = 1'b0;
          dbg_req[2] = 1'b0;
        end
      end
      step();
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL raw missing acks: %0d pending want 0", sb.size());
      sb.delete();
    end else passes++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cpu_req[k] = 1'b0;
      cpu_we[k] = 1'b0;
      cpu_size[k] = SZ_B;
      cpu_addr[k] = '0;
      cpu_wdata[k] = '0;
      dbg_req[k] = 1'b0;
      dbg_we[k] = 1'b0;
      dbg_addr[k] = '0;
      dbg_wdata[k] = '0;
    end
    test_reset();
    test_read();
    test_store();
    test_misaligned();
    test_arb();
    test_reset_mid();
    test_raw();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between two requesters.
- Requester 0 is the multi-cycle CPU's memory interface, used for both fetch and data. Requester 1 is the debug/program loader.
- Sequences each access as ISSUE, then WAIT, then RESP, and generates byte enables from the CPU store-size code.
- Flags misaligned accesses, and exposes cpu_stall so the CPU control FSM holds in sIF/sMEM* until the access completes.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width; fixed at 32.
- LAT, 1, memory read latency in cycles after mem_en; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  write data, LSB-aligned
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned flag, valid with cpu_ack
- cpu_stall  out  1  cpu_req & ~cpu_ack
- dbg_req/dbg_we/dbg_addr/dbg_wdata  in  1/1/AW/DW  loader request; always word size
- dbg_ack  out  1  completion pulse
- rdata  out  DW  registered read data; valid with either ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  byte lanes
- mem_addr  out  AW  word-aligned address (addr[1:0] forced to 0)
- mem_wdata  out  DW  lane-replicated write data
- mem_rdata  in  DW  valid LAT cycles after mem_en

Behaviour:

Reset state:
- Reset values: state=IDLE; all outputs 0; last_grant=DBG, so the CPU wins the first tie.
- A reset mid-transaction abandons the transaction: no ack, mem_en low from the next cycle.

State machine:
- IDLE: sample requests.
  - Only one requester asserting: grant it.
  - Both asserting: grant the one that is not last_grant.
  - Latch we, size, addr, wdata and the grant ID.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: one cycle.
  - mem_en=1 unless the access is misaligned; mem_we=latched we; mem_be and mem_addr driven from the latched values.
  - cnt=LAT. Go to WAIT.
- WAIT: decrement cnt each cycle.
  - In the cycle where cnt==1, capture rdata<=mem_rdata. Reads only; writes and misaligned accesses capture 0.
  - Then go to RESP.
- RESP: ack to the granted requester for exactly one cycle, plus cpu_err if applicable.
  - last_grant<=granted ID. Go to IDLE.

Latency and request timing:
- Request to ack = LAT+2 cycles; the request is sampled in IDLE in cycle 0.
- Back-to-back throughput: one access per LAT+3 cycles.
- Requests are not sampled in ISSUE, WAIT or RESP.
- A requester still holding req in the IDLE cycle after its ack is treated as a new request. Requesters must drop req in the cycle after ack.
- Inputs change while granted: the arbiter uses the latched copies only.

Byte enables and write-data replication (CPU port):
- Byte: be = 0001 << addr[1:0]; wdata replicated {4{wdata[7:0]}}.
- Half: be = addr[1] ? 1100 : 0011; wdata replicated {2{wdata[15:0]}}.
- Word: be = 1111.
- Debug port: always be = 1111.

Misalignment:
- Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
- A misaligned access has no mem_en, keeps the same timing, and gives ack with cpu_err=1 and rdata=0.
- A debug access with addr[1:0]!=0 is word-truncated silently; no error is raised.

Read data:
- rdata returns the raw word. Load extraction and sign-extension are done in the CPU datapath.
- rdata holds its value until the next capture.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE, ISSUE, WAIT, RESP
  - size codes: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, matching the CPU Store encoding
  - grant IDs: CPU=0, DBG=1
- Sub-module mem_be_gen (combinational): size and addr[1:0] and wdata in; be, replicated wdata and misaligned flag out. It is shared with future cache work.

Test Plan:
1. Reset, then cpu_req read of word @0x10 with LAT=1 and mem_rdata=0xDEADBEEF:
   - mem_en in cycle 1 with mem_addr=0x10 and be=1111.
   - cpu_ack in cycle 3 with rdata=0xDEADBEEF.
   - cpu_stall high in cycles 0–2.
2. CPU sb to 0x13 with wdata=0x000000A5:
   - mem_we=1, be=1000, mem_wdata=0xA5A5A5A5.
   - sh to 0x12: be=1100.
3. cpu_req and dbg_req asserted together and held:
   - Grants alternate CPU, DBG, CPU.
   - Acks are 6 cycles apart when LAT=3.
4. CPU lw @0x6:
   - mem_en never asserted.
   - cpu_ack with cpu_err=1 and rdata=0, same timing as an aligned access.
5. rst asserted during WAIT of a DBG write:
   - No dbg_ack.
   - All outputs 0 next cycle.
   - A following tied request is granted to the CPU.
6. LAT=4, dbg write then CPU read at the same address:
   - Read returns the written data.
   - Each ack comes LAT+2=6 cycles after its request was sampled.
